// File: rtl/axi4_line_master_if.sv
// AXI4 bus bundle between the line master and the memory slave.
// One 64-bit data lane; AR/R and AW/W/B channels with master/slave views.
interface axi4_line_master_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_line_master.sv
// Single-outstanding AXI4 master: turns cache-line refill/writeback and uncached
// single-beat requests into INCR bursts and returns one response per request.
module axi4_line_master #(
    parameter int         BEATS  = 4,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic                  req_uncached,
    input  logic [31:0]           req_addr,
    input  logic [64*BEATS-1:0]   req_wdata,
    input  logic [7:0]            req_wstrb,
    output logic                  resp_valid,
    output logic [64*BEATS-1:0]   resp_rdata,
    output logic                  resp_err,
    axi4_line_master_if.master    axi
);
    localparam int          IW        = $clog2(BEATS);
    localparam int          CW        = IW + 1;
    localparam int          LW        = 64 * BEATS;
    localparam logic [31:0] LINE_MASK = ~(32'(8 * BEATS - 1));
    localparam logic [31:0] BEAT_MASK = ~32'd7;
    localparam logic [7:0]  LINE_LEN  = 8'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW_W, S_W, S_B, S_RESP
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   len_reg;
    logic            err_reg;
    logic [LW-1:64]  wline_reg;
    logic [CW-1:0]   cnt_next;
    logic            r_beat_err;
    logic            b_err;
    logic [63:0]     wbeat [1:BEATS-1];

    // Beat 0 is driven straight from the request; only later beats are kept.
    genvar gi;
    generate
        for (gi = 1; gi < BEATS; gi++) begin : g_beat
            assign wbeat[gi] = wline_reg[64*gi +: 64];
        end
    endgenerate

    assign cnt_next   = cnt_reg + CW'(1);
    assign r_beat_err = (axi.rresp != 2'b00) || (axi.rid != AXI_ID) ||
                        (axi.rlast != (cnt_reg == len_reg));
    assign b_err      = (axi.bresp != 2'b00) || (axi.bid != AXI_ID);

    assign axi.arid    = AXI_ID;
    assign axi.arsize  = 3'd3;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.awid    = AXI_ID;
    assign axi.awsize  = 3'd3;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.wid     = AXI_ID;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            len_reg     <= '0;
            err_reg     <= 1'b0;
            wline_reg   <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            axi.araddr  <= '0;
            axi.arlen   <= '0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awaddr  <= '0;
            axi.awlen   <= '0;
            axi.awvalid <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.wlast   <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        len_reg   <= req_uncached ? '0 : CW'(BEATS - 1);
                        if (req_wr) begin
                            wline_reg   <= req_wdata[LW-1:64];
                            axi.awaddr  <= req_addr & (req_uncached ? BEAT_MASK : LINE_MASK);
                            axi.awlen   <= req_uncached ? 8'd0 : LINE_LEN;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            axi.wdata   <= req_wdata[63:0];
                            axi.wstrb   <= req_uncached ? req_wstrb : 8'hFF;
                            axi.wlast   <= req_uncached;
                            state_reg   <= S_AW_W;
                        end else begin
                            resp_rdata  <= '0;
                            axi.araddr  <= req_addr & (req_uncached ? BEAT_MASK : LINE_MASK);
                            axi.arlen   <= req_uncached ? 8'd0 : LINE_LEN;
                            axi.arvalid <= 1'b1;
                            state_reg   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state_reg   <= S_R;
                    end
                end
                S_R: begin
                    if (axi.rvalid) begin
                        resp_rdata[64*cnt_reg[IW-1:0] +: 64] <= axi.rdata;
                        // Burst length is ours, not the slave's: stop on beat len regardless of rlast.
                        if (cnt_reg == len_reg) begin
                            axi.rready <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= err_reg | r_beat_err;
                            state_reg  <= S_RESP;
                        end else begin
                            cnt_reg <= cnt_next;
                            err_reg <= err_reg | r_beat_err;
                        end
                    end
                end
                S_AW_W: begin
                    if (axi.awvalid && axi.awready) begin
                        axi.awvalid <= 1'b0;
                    end
                    if (axi.wvalid && axi.wready) begin
                        axi.wvalid <= 1'b0;
                        axi.wlast  <= 1'b0;
                        cnt_reg    <= cnt_next;
                    end
                    // Leave only once both the address and first data beat are accepted.
                    if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
                        if (len_reg == '0) begin
                            axi.bready <= 1'b1;
                            state_reg  <= S_B;
                        end else begin
                            axi.wvalid <= 1'b1;
                            axi.wdata  <= wbeat[1];
                            axi.wstrb  <= 8'hFF;
                            axi.wlast  <= (len_reg == CW'(1));
                            state_reg  <= S_W;
                        end
                    end
                end
                S_W: begin
                    if (axi.wvalid && axi.wready) begin
                        cnt_reg <= cnt_next;
                        if (axi.wlast) begin
                            axi.wvalid <= 1'b0;
                            axi.wlast  <= 1'b0;
                            axi.bready <= 1'b1;
                            state_reg  <= S_B;
                        end else begin
                            axi.wdata <= wbeat[cnt_next[IW-1:0]];
                            axi.wlast <= (cnt_next == len_reg);
                        end
                    end
                end
                S_B: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= err_reg | b_err;
                        state_reg  <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_line_master.sv
// Directed plus randomized bench for axi4_line_master; a behavioural AXI slave
// and reference model live in the tasks below.
module tb_axi4_line_master;
    localparam int         BEATS  = 4;
    localparam int         LW     = 64 * BEATS;
    localparam logic [3:0] AXI_ID = 4'd0;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          req_valid, req_ready, req_wr, req_uncached;
    logic [31:0]   req_addr;
    logic [LW-1:0] req_wdata;
    logic [7:0]    req_wstrb;
    logic          resp_valid, resp_err;
    logic [LW-1:0] resp_rdata;

    int vectors = 0;
    int miscompares = 0;

    axi4_line_master_if axi ();

    axi4_line_master #(.BEATS(BEATS), .AXI_ID(AXI_ID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_uncached(req_uncached), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .axi(axi)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_base(input logic [31:0] a, input bit unc);
        return unc ? a - (a % 8) : a - (a % (8 * BEATS));
    endfunction

    task automatic wait_accept();
        int t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("req_ready", 256'(req_ready), 256'(1));
    endtask

    // Starts and ends on a falling edge.
    task automatic run_read(input logic [31:0] addr, input bit unc, input int err_beat,
                            input int rlast_mode, input int stall, input bit keep,
                            input bit imm, input int abort_beat);
        int n = unc ? 1 : BEATS;
        logic [31:0] ea = exp_base(addr, unc);
        logic [LW-1:0] line = '0;
        bit exp_err = (err_beat >= 0 && err_beat < n) || (rlast_mode != 0);
        bit hs = 1'b0;
        int t = 0;
        int k = 0;
        bit v;
        for (int i = 0; i < n; i++) line[64*i +: 64] = {$urandom(), $urandom()};
        req_wr = 1'b0; req_uncached = unc; req_addr = addr; req_valid = 1'b1;
        if (imm) chk("b2b_ready", 256'(req_ready), 256'(1));
        else wait_accept();
        @(negedge aclk);
        if (!keep) req_valid = 1'b0;
        chk("arvalid_rise", 256'(axi.arvalid), 256'(1));
        chk("araddr", 256'(axi.araddr), 256'(ea));
        chk("arlen", 256'(axi.arlen), 256'(n - 1));
        chk("arburst_size", 256'({axi.arburst, axi.arsize}), 256'({2'b01, 3'd3}));
        while (!hs && t < 100) begin
            axi.arready = (int'($urandom_range(0, 99)) >= stall);
            hs = axi.arready;
            @(negedge aclk);
            axi.arready = 1'b0;
            if (!hs) chk("ar_hold", 256'({axi.arvalid, axi.araddr}), 256'({1'b1, ea}));
            t++;
        end
        chk("ar_done", 256'({hs, axi.arvalid, axi.rready}), 256'({1'b1, 1'b0, 1'b1}));
        t = 0;
        while (k < n && t < 300) begin
            chk("r_wait", 256'({axi.rready, resp_valid}), 256'({1'b1, 1'b0}));
            if (k == abort_beat) begin
                axi.rvalid = 1'b1; axi.rdata = line[64*k +: 64];
                axi.rresp = 2'b00; axi.rid = AXI_ID; axi.rlast = 1'b0;
                aresetn = 1'b0;
                @(negedge aclk);
                axi.rvalid = 1'b0;
                chk("abort_idle", 256'({axi.rready, axi.arvalid, req_ready, resp_valid}),
                    256'({1'b0, 1'b0, 1'b1, 1'b0}));
                aresetn = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge aclk);
                    chk("abort_quiet", 256'({resp_valid, req_ready}), 256'({1'b0, 1'b1}));
                end
                return;
            end
            v = (int'($urandom_range(0, 99)) >= stall);
            axi.rvalid = v;
            axi.rdata  = line[64*k +: 64];
            axi.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            axi.rid    = AXI_ID;
            axi.rlast  = (rlast_mode == 1) ? (k == 1 || k == n - 1) :
                         (rlast_mode == 2) ? 1'b0 : (k == n - 1);
            @(negedge aclk);
            axi.rvalid = 1'b0;
            if (v) k++;
            t++;
        end
        chk("r_beats", 256'(k), 256'(n));
        chk("resp_pulse", 256'({resp_valid, resp_err, axi.rready}), 256'({1'b1, exp_err, 1'b0}));
        chk("resp_rdata", resp_rdata, line);
        @(negedge aclk);
        chk("resp_end", 256'({resp_valid, req_ready}), 256'({1'b0, 1'b1}));
        chk("rdata_hold", resp_rdata, line);
        $display("read  addr=%h unc=%0d err=%0d data=%h", addr, unc, exp_err, line);
    endtask

    // stall < 0 means wready toggles low on alternate cycles.
    task automatic run_write(input logic [31:0] addr, input bit unc, input logic [LW-1:0] line,
                             input logic [7:0] strb, input bit bresp_err, input bit bid_err,
                             input int stall);
        int n = unc ? 1 : BEATS;
        logic [31:0] ea = exp_base(addr, unc);
        bit exp_err = bresp_err || bid_err;
        bit aw_done = 1'b0;
        bit hs_aw, hs_w, hs;
        int k = 0;
        int t = 0;
        req_wr = 1'b1; req_uncached = unc; req_addr = addr; req_wdata = line;
        req_wstrb = strb; req_valid = 1'b1;
        wait_accept();
        @(negedge aclk);
        req_valid = 1'b0;
        chk("aw_w_rise", 256'({axi.awvalid, axi.wvalid}), 256'({1'b1, 1'b1}));
        chk("awaddr", 256'(axi.awaddr), 256'(ea));
        chk("awlen", 256'(axi.awlen), 256'(n - 1));
        while ((!aw_done || k < n) && t < 300) begin
            chk("awvalid", 256'(axi.awvalid), 256'(!aw_done));
            chk("wvalid", 256'(axi.wvalid), 256'(k < n && (k == 0 || aw_done)));
            if (axi.wvalid) begin
                chk("wdata", 256'(axi.wdata), 256'(line[64*k +: 64]));
                chk("wstrb_wlast", 256'({axi.wstrb, axi.wlast}),
                    256'({unc ? strb : 8'hFF, k == n - 1}));
            end
            axi.awready = (int'($urandom_range(0, 99)) >= (stall < 0 ? 30 : stall));
            axi.wready  = (stall < 0) ? t[0] : (int'($urandom_range(0, 99)) >= stall);
            hs_aw = axi.awvalid && axi.awready;
            hs_w  = axi.wvalid && axi.wready;
            @(negedge aclk);
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            if (hs_aw) aw_done = 1'b1;
            if (hs_w) k++;
            t++;
        end
        chk("w_beats", 256'({aw_done, 8'(k)}), 256'({1'b1, 8'(n)}));
        hs = 1'b0;
        t = 0;
        while (!hs && t < 100) begin
            chk("b_wait", 256'({axi.bready, axi.wvalid, axi.awvalid, resp_valid}),
                256'({1'b1, 1'b0, 1'b0, 1'b0}));
            hs = (int'($urandom_range(0, 99)) >= (stall < 0 ? 0 : stall));
            axi.bvalid = hs;
            axi.bresp  = bresp_err ? 2'b10 : 2'b00;
            axi.bid    = bid_err ? 4'd5 : AXI_ID;
            @(negedge aclk);
            axi.bvalid = 1'b0;
            t++;
        end
        chk("wresp_pulse", 256'({resp_valid, resp_err, axi.bready}), 256'({1'b1, exp_err, 1'b0}));
        @(negedge aclk);
        chk("wresp_end", 256'({resp_valid, req_ready}), 256'({1'b0, 1'b1}));
        $display("write addr=%h unc=%0d strb=%h err=%0d data=%h", addr, unc, strb, exp_err, line);
    endtask

    logic [LW-1:0] rnd_line;

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_uncached = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
        axi.rid = '0; axi.rlast = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
        repeat (3) @(negedge aclk);
        chk("rst_ctrl", 256'({req_ready, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                              axi.bready, axi.wlast, resp_valid, resp_err}),
            256'(9'b1_0000_0000));
        chk("rst_rdata", resp_rdata, '0);
        chk("rst_addr", 256'({axi.araddr, axi.arlen, axi.awaddr, axi.awlen}), 256'(0));
        aresetn = 1'b1;
        @(negedge aclk);

        run_read(32'h8000_0018, 1'b0, -1, 0, 0, 1'b0, 1'b0, -1);
        run_write(32'hA000_0004, 1'b1, {192'd0, 64'h1122_3344_5566_7788}, 8'hF0, 1'b0, 1'b0, 0);
        rnd_line = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
        run_write(32'h8000_1000, 1'b0, rnd_line, 8'h00, 1'b0, 1'b0, -1);
        run_read(32'h8000_2040, 1'b0, 2, 0, 30, 1'b0, 1'b0, -1);
        run_read(32'h8000_2060, 1'b0, -1, 1, 20, 1'b0, 1'b0, -1);
        run_read(32'h8000_2080, 1'b0, -1, 2, 0, 1'b0, 1'b0, -1);
        run_write(32'h8000_3008, 1'b1, rnd_line, 8'h0F, 1'b1, 1'b0, 20);
        run_write(32'h8000_3020, 1'b0, rnd_line, 8'hAA, 1'b0, 1'b1, 20);
        run_read(32'h8000_4000, 1'b0, -1, 0, 0, 1'b0, 1'b0, 2);
        run_read(32'h8000_4000, 1'b0, -1, 0, 0, 1'b0, 1'b0, -1);
        run_read(32'h9000_000D, 1'b1, -1, 0, 10, 1'b0, 1'b0, -1);
        run_read(32'h8000_5000, 1'b0, -1, 0, 0, 1'b1, 1'b0, -1);
        run_read(32'h8000_5020, 1'b0, -1, 0, 0, 1'b0, 1'b1, -1);

        for (int i = 0; i < 24; i++) begin
            rnd_line = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1)
                run_write($urandom(), 1'($urandom_range(0, 1)), rnd_line, 8'($urandom()),
                          1'b0, 1'b0, int'($urandom_range(0, 50)));
            else
                run_read($urandom(), 1'($urandom_range(0, 1)), -1, 0,
                         int'($urandom_range(0, 50)), 1'b0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
